// File: rtl/mem_access_seq.sv
// Memory-side access sequencer: turns one-cycle read/write requests into the
// MAR/MDR load, MDR mux select and memory strobe pattern, with wait states and timeout abort.
module mem_access_seq #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       mem_ready,
  output logic       mar_in,
  output logic       mdr_in,
  output logic       MDR_read,
  output logic       mem_read,
  output logic       mem_write,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD_WAIT, S_RD_CAP, S_WR_DATA, S_WR_WAIT, S_DONE, S_ABORT
  } state_e;

  state_e           state_q, state_d;
  logic             op_wr_q, op_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       out_q, out_d;
  logic             timeout_hit;

  // Output bit order: {mar_in, mdr_in, MDR_read, mem_read, mem_write, busy, done, err}
  function automatic logic [7:0] decode(input state_e s);
    logic [7:0] o;
    o = 8'h00;
    case (s)
      S_IDLE:    o = 8'b0000_0000;
      S_ADDR:    o = 8'b1000_0100;
      S_RD_WAIT: o = 8'b0011_0100;
      S_RD_CAP:  o = 8'b0111_0100;
      S_WR_DATA: o = 8'b0100_0100;
      S_WR_WAIT: o = 8'b0000_1100;
      S_DONE:    o = 8'b0000_0110;
      S_ABORT:   o = 8'b0000_0111;
      default:   o = 8'b0000_0000;
    endcase
    return o;
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          state_d = S_ADDR;
          op_wr_d = 1'b0;
        end else if (wr_req) begin
          state_d = S_ADDR;
          op_wr_d = 1'b1;
        end
      end
      S_ADDR:    state_d = op_wr_q ? S_WR_DATA : S_RD_WAIT;
      S_WR_DATA: state_d = S_WR_WAIT;
      S_RD_WAIT, S_WR_WAIT: begin
        // mem_ready wins over abort even in the last allowed wait cycle
        if (mem_ready)        state_d = (state_q == S_RD_WAIT) ? S_RD_CAP : S_DONE;
        else if (timeout_hit) state_d = S_ABORT;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      S_RD_CAP:  state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ABORT:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    out_d = decode(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign {mar_in, mdr_in, MDR_read, mem_read, mem_write, busy, done, err} = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq (TIMEOUT=4): per-cycle output vectors
// {mar_in, mdr_in, MDR_read, mem_read, mem_write, busy, done, err} against hand-derived patterns.
module tb_mem_access_seq;

  logic       clock = 1'b0;
  logic       reset, rd_req, wr_req, mem_ready;
  logic       mar_in, mdr_in, MDR_read, mem_read, mem_write, busy, done, err;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] E_IDLE  = 8'h00;
  localparam logic [7:0] E_ADDR  = 8'h84;
  localparam logic [7:0] E_RDW   = 8'h34;
  localparam logic [7:0] E_RDC   = 8'h74;
  localparam logic [7:0] E_WRD   = 8'h44;
  localparam logic [7:0] E_WRW   = 8'h0C;
  localparam logic [7:0] E_DONE  = 8'h06;
  localparam logic [7:0] E_ABORT = 8'h07;

  mem_access_seq #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
    .mem_ready(mem_ready), .mar_in(mar_in), .mdr_in(mdr_in),
    .MDR_read(MDR_read), .mem_read(mem_read), .mem_write(mem_write),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, got stuck want finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Drive inputs sampled at the next edge, then check the outputs that edge produces.
  task automatic cycle(input string tag, input logic r, input logic w, input logic rdy,
                       input logic [7:0] exp);
    rd_req    = r;
    wr_req    = w;
    mem_ready = rdy;
    @(posedge clock);
    #1;
    check_eq(tag, {mar_in, mdr_in, MDR_read, mem_read, mem_write, busy, done, err}, exp);
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b1; wr_req = 1'b0; mem_ready = 1'b0;
    cycle("rst0", 1, 0, 0, E_IDLE);
    cycle("rst1", 1, 0, 0, E_IDLE);
    reset = 1'b0;
    cycle("post_rst_idle", 0, 0, 0, E_IDLE);

    // zero-wait read
    cycle("rd0_addr", 1, 0, 1, E_ADDR);
    cycle("rd0_wait", 0, 0, 1, E_RDW);
    cycle("rd0_cap",  0, 0, 1, E_RDC);
    cycle("rd0_done", 0, 0, 1, E_DONE);
    cycle("rd0_idle", 0, 0, 1, E_IDLE);

    // write, ready in 4th wait cycle (also the last allowed: ready beats abort)
    cycle("wr3_addr",  0, 1, 0, E_ADDR);
    cycle("wr3_data",  0, 0, 0, E_WRD);
    cycle("wr3_wait0", 0, 0, 0, E_WRW);
    cycle("wr3_wait1", 0, 0, 0, E_WRW);
    cycle("wr3_wait2", 0, 0, 0, E_WRW);
    cycle("wr3_wait3", 0, 0, 0, E_WRW);
    cycle("wr3_done",  0, 0, 1, E_DONE);
    cycle("wr3_idle",  0, 0, 0, E_IDLE);

    // read timeout
    cycle("to_addr",  1, 0, 0, E_ADDR);
    for (int i = 0; i < 4; i++) cycle("to_wait", 0, 0, 0, E_RDW);
    cycle("to_abort", 0, 0, 0, E_ABORT);
    cycle("to_idle",  0, 0, 0, E_IDLE);

    // read with ready in the 4th wait cycle
    cycle("rl_addr", 1, 0, 0, E_ADDR);
    for (int i = 0; i < 4; i++) cycle("rl_wait", 0, 0, 0, E_RDW);
    cycle("rl_cap",  0, 0, 1, E_RDC);
    cycle("rl_done", 0, 0, 0, E_DONE);
    cycle("rl_idle", 0, 0, 0, E_IDLE);

    // collision: read wins; a write pulse while busy is dropped
    cycle("col_addr",  1, 1, 1, E_ADDR);
    cycle("col_wait",  0, 0, 1, E_RDW);
    cycle("col_cap",   0, 1, 1, E_RDC);
    cycle("col_done",  0, 1, 1, E_DONE);
    cycle("col_idle",  0, 0, 1, E_IDLE);
    cycle("col_idle2", 0, 0, 1, E_IDLE);

    // request held through DONE: re-accepted from IDLE
    cycle("b2b_addr",  1, 0, 1, E_ADDR);
    cycle("b2b_wait",  1, 0, 1, E_RDW);
    cycle("b2b_cap",   1, 0, 1, E_RDC);
    cycle("b2b_done",  1, 0, 1, E_DONE);
    cycle("b2b_idle",  1, 0, 1, E_IDLE);
    cycle("b2b_addr2", 1, 0, 1, E_ADDR);
    cycle("b2b_wait2", 0, 0, 1, E_RDW);
    cycle("b2b_cap2",  0, 0, 1, E_RDC);
    cycle("b2b_done2", 0, 0, 1, E_DONE);
    cycle("b2b_idle2", 0, 0, 1, E_IDLE);

    // reset in the 2nd wait cycle: no done/err, then a normal read
    cycle("mr_addr",  1, 0, 0, E_ADDR);
    cycle("mr_wait0", 0, 0, 0, E_RDW);
    cycle("mr_wait1", 0, 0, 0, E_RDW);
    reset = 1'b1;
    cycle("mr_reset", 0, 0, 1, E_IDLE);
    reset = 1'b0;
    cycle("mr_idle",  0, 0, 0, E_IDLE);
    cycle("mr_addr2", 1, 0, 0, E_ADDR);
    cycle("mr_wait2", 0, 0, 0, E_RDW);
    cycle("mr_cap2",  0, 0, 1, E_RDC);
    cycle("mr_done2", 0, 0, 0, E_DONE);
    cycle("mr_idle2", 0, 0, 0, E_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Sequencer for the memory-side datapath. It drives the MAR load, the MDR load, the MDR source-mux select and the memory strobes.
- It turns a one-cycle read or write request from the control unit into the correct per-cycle control pattern, including variable memory wait states.
- A timeout aborts a stalled access.
- It sits between the control unit and the MAR/MDR registers plus the external memory interface.

Parameters:
- TIMEOUT, 15: maximum number of wait-state cycles per access before abort. 0 disables the timeout (waits forever).
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- rd_req  in  1  read request from the control unit; sampled only in IDLE.
- wr_req  in  1  write request from the control unit; sampled only in IDLE.
- mem_ready  in  1  memory acknowledge; valid only in wait states.
- mar_in  out  1  load enable for the MAR (captures BusMuxOut).
- mdr_in  out  1  load enable for the MDR.
- MDR_read  out  1  MDR source-mux select: 1 = mdata_in (memory), 0 = BusMuxOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse marking the end of an access (normal or aborted).
- err  out  1  one-cycle pulse, coincident with done, on timeout abort.

Behaviour:
- Outputs are Moore: decoded from the registered state only, with no input-to-output combinational path.
- On reset the state is IDLE and the counter is 0, so every output is 0 in the cycle after reset is sampled. Reset asserted mid-access overrides everything: strobes drop next cycle and no done or err is issued.
- States and their asserted outputs (all others are 0):
  - IDLE: none.
  - ADDR: mar_in, busy.
  - RD_WAIT: mem_read, MDR_read, busy.
  - RD_CAP: mem_read, MDR_read, mdr_in, busy.
  - WR_DATA: mdr_in, busy (MDR_read=0, so the MDR loads BusMuxOut).
  - WR_WAIT: mem_write, busy.
  - DONE: done, busy.
  - ABORT: done, err, busy.
- Transitions:
  - IDLE: rd_req -> ADDR with op=read. Otherwise wr_req -> ADDR with op=write. Read wins when both requests are high; the write is dropped and not queued.
  - ADDR: -> RD_WAIT if op=read, -> WR_DATA if op=write. op is latched on leaving IDLE.
  - WR_DATA: -> WR_WAIT. The control unit must present the address on the bus in the ADDR cycle and the data in the WR_DATA cycle.
  - RD_WAIT: mem_ready -> RD_CAP. Otherwise, if TIMEOUT!=0 and cnt==TIMEOUT-1 -> ABORT. Otherwise cnt <= cnt+1.
  - WR_WAIT: mem_ready -> DONE. The timeout rule is the same as in RD_WAIT.
  - RD_CAP: -> DONE. DONE: -> IDLE. ABORT: -> IDLE.
- Counter:
  - cnt is cleared on every entry to RD_WAIT or WR_WAIT, and is 0 in all other states.
  - With TIMEOUT=N, at most N wait cycles are spent; abort is entered on the edge ending the Nth wait cycle without mem_ready.
  - mem_ready in the Nth cycle takes priority over abort.
- Latency (request high at edge k): ADDR in cycle k+1 and first wait cycle at k+2.
  - Read with mem_ready in the first wait cycle: RD_CAP at k+3, done at k+4, IDLE at k+5.
  - Write with mem_ready in the first wait cycle: WR_DATA at k+2, WR_WAIT at k+3, done at k+4.
- Ignored inputs:
  - rd_req and wr_req are ignored while busy=1. A request held through DONE is accepted again once the state is IDLE (back-to-back access).
  - mem_ready outside the wait states is ignored.

Test Plan:
- Reset: assert reset for 2 cycles with rd_req=1 -> all outputs 0, busy=0, no ADDR entered while reset is high.
- Zero-wait read: rd_req pulse at cycle 0, mem_ready=1 always -> mar_in@1; mem_read+MDR_read@2–3; mdr_in@3; done@4; busy 1..4.
- Write with 3 wait states: wr_req pulse, mem_ready rises in the 4th WR_WAIT cycle -> mar_in@1, mdr_in with MDR_read=0 @2, mem_write@3–6, done@7, err=0.
- Timeout: TIMEOUT=4, read with mem_ready=0 -> mem_read high exactly 4 cycles (@2–5), done=err=1 @6, idle @7, mdr_in never asserted. Repeat with mem_ready=1 in the 4th wait cycle -> RD_CAP, no err.
- Collision and ignore: rd_req=wr_req=1 in IDLE -> read sequence only, mem_write never asserted; wr_req pulse while busy -> ignored, no second access.
- Reset mid-operation: assert reset in the 2nd RD_WAIT cycle -> next cycle mem_read=0, busy=0, no done pulse; a new rd_req afterwards runs a normal sequence.
